// File: rtl/token_dispenser_if.sv
// Command/status bundle between the command FSM and one token chute.
// The servo pulse train rides along so each chute is one connection.
interface token_dispenser_if;
    logic       start;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] dispensed;
    logic       servo_pwm;

    modport master (
        output start, count,
        input  busy, done, dispensed, servo_pwm
    );

    modport slave (
        input  start, count,
        output busy, done, dispensed, servo_pwm
    );
endinterface

// File: rtl/token_dispenser.sv
// Servo token dispenser: one PUSH/REST stroke per token.
// Arm position changes only on PWM frame boundaries.
module token_dispenser #(
    parameter int PWM_PERIOD  = 1000000,
    parameter int PULSE_REST  = 50000,
    parameter int PULSE_PUSH  = 100000,
    parameter int HOLD_FRAMES = 25,
    parameter int MAX_COUNT   = 15
) (
    input  logic clk50m,
    input  logic reset,
    token_dispenser_if.slave bus
);
    localparam int CW = $clog2(PWM_PERIOD);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int NW = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] LAST   = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] REST_W = CW'(PULSE_REST);
    localparam logic [CW-1:0] PUSH_W = CW'(PULSE_PUSH);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [NW-1:0] N_MAX  = NW'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_PUSH,
        S_RETURN
    } state_t;

    state_t        state_q, state_d;
    logic          pos_q, pos_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [NW-1:0] n_q, n_d;
    logic [7:0]    disp_q, disp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] width_q;
    logic          pwm_q;
    logic          frame_end;
    logic [CW-1:0] pos_w;
    logic [CW-1:0] cur_w;
    logic [NW-1:0] req;

    assign frame_end = (cnt_q == LAST);
    assign pos_w     = pos_q ? PUSH_W : REST_W;
    // Width is taken from the arm position only at the frame start.
    assign cur_w     = (cnt_q == '0) ? pos_w : width_q;
    assign req       = (bus.count > 8'(MAX_COUNT))
                       ? N_MAX : bus.count[NW-1:0];

    always_ff @(posedge clk50m) begin
        if (reset) begin
            cnt_q   <= '0;
            width_q <= REST_W;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= frame_end ? '0 : cnt_q + 1'b1;
            width_q <= cur_w;
            pwm_q   <= (cnt_q < cur_w);
        end
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_q   <= 1'b0;
            hold_q  <= '0;
            n_q     <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            n_q     <= n_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        n_d     = n_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pos_d = 1'b0;
                if (bus.start) begin
                    n_d    = req;
                    disp_d = '0;
                    if (req == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (frame_end) begin
                    pos_d   = 1'b1;
                    hold_d  = '0;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (frame_end) begin
                    if (hold_q == H_LAST) begin
                        pos_d   = 1'b0;
                        hold_d  = '0;
                        disp_d  = disp_q + 8'd1;
                        state_d = S_RETURN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_RETURN: begin
                if (frame_end) begin
                    if (hold_q == H_LAST) begin
                        hold_d = '0;
                        if (disp_q == 8'(n_q)) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            pos_d   = 1'b1;
                            state_d = S_PUSH;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dispensed = disp_q;
    assign bus.servo_pwm = pwm_q;
endmodule
